// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the TX sequencer state encoding.
// No logic here; imported by the TX controller and the CRC helper.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam int          BYTE_CNT_W   = 11;

endpackage

// File: rtl/eth_frame_tx_ctrl_if.sv
// Payload-in / wire-byte-out bundle of the Ethernet TX sequencer plus its status pulses.
// master = payload source and wire sink, slave = the sequencer.
interface eth_frame_tx_ctrl_if;

    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       m_tvalid;
    logic [7:0] m_tdata;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    modport master (
        output s_tvalid, s_tdata, s_tlast,
        input  s_tready, m_tvalid, m_tdata, busy, frame_done, underrun
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tlast,
        output s_tready, m_tvalid, m_tdata, busy, frame_done, underrun
    );

endinterface

// File: rtl/crc32_d8.sv
// IEEE 802.3 CRC32 (reflected), one byte per call; purely combinational, no handshake.
// Returns the running register, not its complement; callers invert for the FCS.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_frame_tx_ctrl.sv
// Ethernet TX sequencer: preamble, SFD, payload, pad, FCS, IFG; one wire byte per clk, output one cycle behind state.
// Payload is pulled only in DATA (s_tready from state); a missing byte there aborts the frame as underrun.
module eth_frame_tx_ctrl
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic                clk,
    input  logic                rst,
    eth_frame_tx_ctrl_if.slave  bus
);

    localparam logic [7:0]            PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]            IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [7:0]            FCS_LAST = 8'd3;
    localparam logic [BYTE_CNT_W-1:0] MIN_CNT  = BYTE_CNT_W'(MIN_FRAME);
    localparam logic [BYTE_CNT_W-1:0] CNT_MAX  = '1;

    tx_state_e             state_q, state_d;
    logic [7:0]            phase_q, phase_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]           crc_q, crc_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [7:0]            m_tdata_q, m_tdata_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underrun_q, underrun_d;

    logic [7:0]            crc_byte;
    logic [31:0]           crc_next;
    logic [31:0]           crc_inv;
    logic [7:0]            fcs_byte;
    logic [BYTE_CNT_W-1:0] cnt_inc;

    // PAD feeds zeros into the CRC, DATA feeds the payload byte
    assign crc_byte = (state_q == ST_DATA) ? bus.s_tdata : 8'h00;
    assign crc_inv  = ~crc_q;
    assign fcs_byte = crc_inv[{phase_q[1:0], 3'b000} +: 8];
    assign cnt_inc  = (byte_cnt_q == CNT_MAX) ? CNT_MAX : byte_cnt_q + 1'b1;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        m_tvalid_d   = 1'b0;
        m_tdata_d    = 8'h00;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = 8'd0;
                if (bus.s_tvalid) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = ETH_PREAMBLE;
                phase_d    = phase_q + 8'd1;
                if (phase_q == PRE_LAST) begin
                    phase_d = 8'd0;
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = ETH_SFD;
                crc_d      = CRC32_INIT;
                byte_cnt_d = '0;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                if (bus.s_tvalid) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = bus.s_tdata;
                    crc_d      = crc_next;
                    byte_cnt_d = cnt_inc;
                    if (bus.s_tlast) begin
                        phase_d = 8'd0;
                        state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    underrun_d = 1'b1;
                    phase_d    = 8'd0;
                    state_d    = ST_IFG;
                end
            end
            ST_PAD: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = 8'h00;
                crc_d      = crc_next;
                byte_cnt_d = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    phase_d = 8'd0;
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = fcs_byte;
                phase_d    = phase_q + 8'd1;
                if (phase_q == FCS_LAST) begin
                    frame_done_d = 1'b1;
                    phase_d      = 8'd0;
                    state_d      = ST_IFG;
                end
            end
            ST_IFG: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == IFG_LAST) begin
                    phase_d = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                phase_d = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 8'd0;
            byte_cnt_q   <= '0;
            crc_q        <= CRC32_INIT;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= 8'h00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.s_tready   = (state_q == ST_DATA);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.m_tvalid   = m_tvalid_q;
    assign bus.m_tdata    = m_tdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_eth_frame_tx_ctrl.sv
// Bench for eth_frame_tx_ctrl: random payloads against a table-driven frame model.
module tb_eth_frame_tx_ctrl;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       fd;
        logic       ur;
        logic       bz;
    } mon_t;

    logic clk = 1'b0;
    logic rst;
    eth_frame_tx_ctrl_if bus();

    eth_frame_tx_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] crc_in;
    logic [7:0]  crc_dat;
    logic [31:0] crc_out;

    crc32_d8 u_crc (
        .crc_in  (crc_in),
        .data_in (crc_dat),
        .crc_out (crc_out)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] crc_tab[256];
    mon_t        mon_q[$];
    logic        mon_en = 1'b0;
    int          bst[$];
    int          blen[$];

    always @(negedge clk) begin
        if (mon_en) begin
            mon_t m;
            m.v  = bus.m_tvalid;
            m.d  = bus.m_tdata;
            m.fd = bus.frame_done;
            m.ur = bus.underrun;
            m.bz = bus.busy;
            mon_q.push_back(m);
        end
    end

    function automatic void build_tab();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic bq_t rand_payload(int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic bq_t sub(bq_t p, int a, int b);
        bq_t r;
        for (int i = a; i <= b; i++) r.push_back(p[i]);
        return r;
    endfunction

    // On-wire frame: 7x55, D5, payload zero-padded to 60, then ~CRC LSB byte first
    function automatic bq_t exp_frame(bq_t p);
        bq_t f;
        bq_t body;
        logic [31:0] c;
        body = p;
        c = 32'hFFFFFFFF;
        while (body.size() < 60) body.push_back(8'h00);
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) begin
            f.push_back(body[i]);
            c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        return f;
    endfunction

    function automatic void split();
        bst.delete();
        blen.delete();
        for (int i = 0; i < mon_q.size(); i++) begin
            if (mon_q[i].v && (i == 0 || !mon_q[i-1].v)) begin
                int j;
                j = i;
                while (j < mon_q.size() && mon_q[j].v) j++;
                bst.push_back(i);
                blen.push_back(j - i);
            end
        end
    endfunction

    // -1 when burst b equals e, -2 on length difference, else first differing index
    function automatic int burst_diff(int b, bq_t e);
        if (blen[b] != e.size()) return -2;
        for (int k = 0; k < e.size(); k++)
            if (mon_q[bst[b] + k].d !== e[k]) return k;
        return -1;
    endfunction

    function automatic int count_fd();
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].fd) n++;
        return n;
    endfunction

    function automatic int count_ur();
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].ur) n++;
        return n;
    endfunction

    function automatic int count_v();
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].v) n++;
        return n;
    endfunction

    function automatic int last_fd_idx();
        int r = -1;
        foreach (mon_q[i]) if (mon_q[i].fd) r = i;
        return r;
    endfunction

    task automatic start_mon();
        mon_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic send(input bq_t data, input int len1, input int drop_at);
        int   idx = 0;
        int   guard = 0;
        logic rdy;
        bit   dropped = 0;
        @(posedge clk); #1;
        while (idx < data.size() && guard < 2000) begin
            bus.s_tdata  = data[idx];
            bus.s_tlast  = (idx == len1 - 1) || (idx == data.size() - 1);
            bus.s_tvalid = 1'b1;
            if (!dropped && idx == drop_at && bus.s_tready) begin
                bus.s_tvalid = 1'b0;
                dropped = 1;
            end
            rdy = bus.s_tready;
            @(posedge clk); #1;
            if (rdy && bus.s_tvalid) idx++;
            guard++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tdata  = 8'h00;
        total++;
        if (idx != data.size()) begin
            bad++;
            $display("FAIL send_accept got=%0d exp=%0d", idx, data.size());
        end
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (bus.busy && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle busy=%0b exp=0", name, bus.busy);
        end
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%0b exp=0", bus.m_tvalid); end
        total++; if (bus.m_tdata !== 8'h00) begin bad++; $display("FAIL rst_m_tdata got=%h exp=00", bus.m_tdata); end
        total++; if (bus.s_tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready got=%0b exp=0", bus.s_tready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%0b exp=0", bus.frame_done); end
        total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%0b exp=0", bus.underrun); end
        bus.s_tvalid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_crc32();
        string       s;
        logic [31:0] c;
        logic [31:0] m;
        logic [7:0]  b;
        s = "123456789";
        c = 32'hFFFFFFFF;
        for (int i = 0; i < s.len(); i++) begin
            crc_in = c; crc_dat = s[i]; #1; c = crc_out;
        end
        total++; if (~c !== 32'hCBF43926) begin bad++; $display("FAIL crc_check got=%h exp=cbf43926", ~c); end
        c = 32'hFFFFFFFF;
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 32; i++) begin
            b = 8'($urandom);
            crc_in = c; crc_dat = b; #1; c = crc_out;
            m = crc_tab[m[7:0] ^ b] ^ (m >> 8);
        end
        total++; if (c !== m) begin bad++; $display("FAIL crc_random got=%h exp=%h", c, m); end
    endtask

    task automatic test_full_frame();
        bq_t p, e;
        int  d;
        p = rand_payload(60);
        e = exp_frame(p);
        start_mon(); send(p, 60, -1); wait_idle("full"); split();
        total++; if (count_v() != 72) begin bad++; $display("FAIL full_valid_cycles got=%0d exp=72", count_v()); end
        total++;
        if (bst.size() != 1) begin bad++; $display("FAIL full_bursts got=%0d exp=1", bst.size()); end
        else begin
            d = burst_diff(0, e);
            total++; if (d != -1) begin bad++; $display("FAIL full_bytes diff_at=%0d exp=-1", d); end
            total++;
            if (count_fd() != 1 || last_fd_idx() != bst[0] + blen[0] - 1) begin
                bad++; $display("FAIL full_frame_done got_n=%0d at=%0d exp_n=1 at=%0d", count_fd(), last_fd_idx(), bst[0] + blen[0] - 1);
            end
        end
        total++; if (count_ur() != 0) begin bad++; $display("FAIL full_underrun got=%0d exp=0", count_ur()); end
    endtask

    task automatic test_pad();
        bq_t p, e;
        int  d, z;
        p = rand_payload(14);
        e = exp_frame(p);
        start_mon(); send(p, 14, -1); wait_idle("pad"); split();
        total++;
        if (bst.size() != 1) begin bad++; $display("FAIL pad_bursts got=%0d exp=1", bst.size()); end
        else begin
            total++; if (blen[0] != 72) begin bad++; $display("FAIL pad_len got=%0d exp=72", blen[0]); end
            z = 0;
            for (int k = 22; k < 68 && bst[0] + k < mon_q.size(); k++) if (mon_q[bst[0] + k].d === 8'h00) z++;
            total++; if (z != 46) begin bad++; $display("FAIL pad_zero_bytes got=%0d exp=46", z); end
            d = burst_diff(0, e);
            total++; if (d != -1) begin bad++; $display("FAIL pad_bytes diff_at=%0d exp=-1", d); end
        end
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2, all;
        int  l1, l2, d;
        l1 = $urandom_range(20, 70);
        l2 = $urandom_range(20, 70);
        p1 = rand_payload(l1);
        p2 = rand_payload(l2);
        all = p1;
        foreach (p2[i]) all.push_back(p2[i]);
        start_mon(); send(all, l1, -1); wait_idle("b2b"); split();
        total++;
        if (bst.size() != 2) begin bad++; $display("FAIL b2b_bursts got=%0d exp=2", bst.size()); end
        else begin
            d = burst_diff(0, exp_frame(p1));
            total++; if (d != -1) begin bad++; $display("FAIL b2b_frame1 diff_at=%0d exp=-1", d); end
            d = burst_diff(1, exp_frame(p2));
            total++; if (d != -1) begin bad++; $display("FAIL b2b_frame2 diff_at=%0d exp=-1", d); end
            total++;
            if (bst[1] - (bst[0] + blen[0]) != 13) begin
                bad++; $display("FAIL b2b_gap got=%0d exp=13", bst[1] - (bst[0] + blen[0]));
            end
        end
        total++; if (count_fd() != 2) begin bad++; $display("FAIL b2b_frame_done got=%0d exp=2", count_fd()); end
    endtask

    task automatic test_underrun();
        bq_t p, e;
        int  d, u;
        p = rand_payload(40);
        e = exp_frame(sub(p, 0, 19));
        start_mon(); send(p, 40, 20); wait_idle("urun"); split();
        total++; if (count_ur() != 1) begin bad++; $display("FAIL urun_pulses got=%0d exp=1", count_ur()); end
        total++;
        if (bst.size() != 2) begin bad++; $display("FAIL urun_bursts got=%0d exp=2", bst.size()); end
        else begin
            total++; if (blen[0] != 28) begin bad++; $display("FAIL urun_cut_len got=%0d exp=28", blen[0]); end
            d = 0;
            for (int k = 0; k < 28; k++) if (mon_q[bst[0] + k].d !== e[k]) d++;
            total++; if (d != 0) begin bad++; $display("FAIL urun_cut_bytes got_bad=%0d exp=0", d); end
            u = bst[0] + blen[0];
            total++;
            if (mon_q[u].ur !== 1'b1 || mon_q[u + 11].bz !== 1'b1 || mon_q[u + 12].bz !== 1'b0) begin
                bad++; $display("FAIL urun_ifg ur=%0b bz11=%0b bz12=%0b exp=1 1 0", mon_q[u].ur, mon_q[u + 11].bz, mon_q[u + 12].bz);
            end
            d = burst_diff(1, exp_frame(sub(p, 20, 39)));
            total++; if (d != -1) begin bad++; $display("FAIL urun_next_frame diff_at=%0d exp=-1", d); end
        end
        total++; if (count_fd() != 1) begin bad++; $display("FAIL urun_frame_done got=%0d exp=1", count_fd()); end
    endtask

    task automatic test_reset_mid_fcs();
        bq_t p, p2;
        int  d;
        p = rand_payload(64);
        start_mon(); send(p, 64, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_m_tvalid got=%0b exp=0", bus.m_tvalid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.m_tdata !== 8'h00) begin bad++; $display("FAIL rstmid_m_tdata got=%h exp=00", bus.m_tdata); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        split();
        total++;
        if (bst.size() != 1 || count_fd() != 0) begin
            bad++; $display("FAIL rstmid_abort bursts=%0d fd=%0d exp=1 0", bst.size(), count_fd());
        end else begin
            total++; if (blen[0] != 72) begin bad++; $display("FAIL rstmid_cut_len got=%0d exp=72", blen[0]); end
        end
        p2 = rand_payload($urandom_range(30, 90));
        start_mon(); send(p2, p2.size(), -1); wait_idle("clean"); split();
        total++;
        if (bst.size() != 1) begin bad++; $display("FAIL clean_bursts got=%0d exp=1", bst.size()); end
        else begin
            d = burst_diff(0, exp_frame(p2));
            total++; if (d != -1) begin bad++; $display("FAIL clean_bytes diff_at=%0d exp=-1", d); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.s_tlast  = 1'b0;
        crc_in  = 32'h0;
        crc_dat = 8'h00;
        build_tab();
        test_reset();
        test_crc32();
        test_full_frame();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_reset_mid_fcs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
